// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined EX-stage ALU: opcode encodings and controller states.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle of alu_pipe; slave is the ALU side, master the requester/consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [alu_pkg::ALU_OP_W-1:0] op;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic [TAG_W-1:0]             in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             r;
  logic [TAG_W-1:0]             out_tag;
  logic                         zero;
  logic                         neg;
  logic                         carry;
  logic                         ovf;
  logic                         illegal;

  modport slave (
    input  in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, r, out_tag, zero, neg, carry, ovf, illegal
  );

  modport master (
    output in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, r, out_tag, zero, neg, carry, ovf, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_sum;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  // The final step's sum is offered combinationally so the caller loads it on the last edge.
  assign product  = step_sum;
  assign busy     = busy_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU with registered result and NZCV flags.
// Define ALU_PIPE_MUL_EN to support MUL through the iterative multiplier; otherwise MUL is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_pipe_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  fsm_state_t       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, illegal_q, illegal_d, out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_ill;

  logic             in_ready, accept, load;
  logic [WIDTH-1:0] ld_r;
  logic [TAG_W-1:0] ld_tag;
  logic             ld_c, ld_v, ld_ill;

  logic             is_mul, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [TAG_W-1:0] mul_tag;

  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt    = bus.b[SH_W-1:0];

  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        // carry is "no borrow", i.e. a >= b unsigned.
        alu_r = diff_ext[WIDTH-1:0];
        alu_c = ~diff_ext[WIDTH];
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_r = bus.a << shamt;
      OP_SRL:  alu_r = bus.a >> shamt;
      OP_SRA:  alu_r = $unsigned($signed(bus.a) >>> shamt);
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [TAG_W-1:0] mul_tag_q, mul_tag_d;
  logic             mul_start;

  assign is_mul    = (bus.op == OP_MUL);
  assign mul_start = (state_q == IDLE) && accept && is_mul;
  assign mul_tag_d = mul_start ? bus.in_tag : mul_tag_q;
  assign mul_tag   = mul_tag_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_tag_q <= '0;
    end else begin
      mul_tag_q <= mul_tag_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign mul_tag  = '0;
`endif

  // A pending result blocks acceptance, so a finishing multiply always finds the output free.
  assign in_ready = (state_q == IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ld_r    = alu_r;
    ld_c    = alu_c;
    ld_v    = alu_v;
    ld_ill  = alu_ill;
    ld_tag  = bus.in_tag;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MUL_BUSY;
          end else begin
            load = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          load    = 1'b1;
          ld_r    = mul_prod;
          ld_c    = 1'b0;
          ld_v    = 1'b0;
          ld_ill  = 1'b0;
          ld_tag  = mul_tag;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    r_d         = r_q;
    tag_d       = tag_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    if (load) begin
      out_valid_d = 1'b1;
      r_d         = ld_r;
      tag_d       = ld_tag;
      zero_d      = (ld_r == '0);
      neg_d       = ld_r[WIDTH-1];
      carry_d     = ld_c;
      ovf_d       = ld_v;
      illegal_d   = ld_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      tag_q       <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      tag_q       <= tag_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.out_tag   = tag_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases plus random traffic with random back-pressure.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  tag;
    logic        z, n, c, v, ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  exp_t sb_q[$];

  alu_pipe_if #(.WIDTH(W), .TAG_W(4)) bus ();

  alu_pipe #(.WIDTH(W), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain wide arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
    exp_t e;
    longint sa, sb, s;
    longint unsigned ua, ub, u;
    logic [4:0] sh;
    e = '0;
    e.tag = tag;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = b[4:0];
    case (op)
      4'd0: begin
        u = ua + ub; e.r = u[31:0]; e.c = u[32];
        s = sa + sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        e.r = a - b; e.c = (a >= b);
        s = sa - sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: e.r = a ^ b;
      4'd3: e.r = a & b;
      4'd4: e.r = a | b;
      4'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: e.r = (ua < ub) ? 32'd1 : 32'd0;
      4'd7: e.r = a << sh;
      4'd8: e.r = a >> sh;
      4'd9: begin s = sa >>> sh; e.r = s[31:0]; end
`ifdef ALU_PIPE_MUL_EN
      4'd10: begin u = ua * ub; e.r = u[31:0]; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Consumer: out_ready updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshakes sampled on the falling edge, ahead of the edge that completes them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got r=%h tag=%h expected none", bus.r, bus.out_tag);
          end else begin
            e = sb_q.pop_front();
            chk("result", {bus.r, bus.out_tag}, {e.r, e.tag});
            chk("flags", {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal},
                {e.z, e.n, e.c, e.v, e.ill});
            $display("txn tag=%h r=%h flags(zncvi)=%b%b%b%b%b", bus.out_tag, bus.r,
                     bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          sb_q.push_back(model(bus.op, bus.a, bus.b, bus.in_tag));
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic set_rdy(input int m);
    @(negedge clk);
    rdy_mode = m;
  endtask

  // Call just after a rising edge; returns just after the accepting edge with in_valid dropped.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int n = 0;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.in_tag = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    to_drive();
    send(op, a, b, tag);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t [5];
    t[0] = 32'h0; t[1] = 32'h1; t[2] = 32'h7FFF_FFFF; t[3] = 32'h8000_0000; t[4] = 32'hFFFF_FFFF;
    return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 4)] : 32'($urandom());
  endfunction

  initial begin
    int n;
    int stray;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_r", bus.r, 0);
    chk("reset_flags", {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal}, 5'b10000);
    chk("reset_valid_ready_tag", {bus.out_valid, bus.in_ready, bus.out_tag}, {1'b0, 1'b1, 4'h0});

    do_op(4'd0, 32'd5, 32'd7, 4'h1);
    chk("add_5_7", {bus.out_valid, bus.zero, bus.r}, {1'b1, 1'b0, 32'd12});
    do_op(4'd1, 32'd3, 32'd5, 4'h2);
    chk("sub_3_5", {bus.r, bus.neg, bus.carry, bus.ovf}, {32'hFFFF_FFFE, 3'b100});
    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 4'h3);
    chk("add_ovf", {bus.r, bus.carry, bus.ovf}, {32'h8000_0000, 2'b01});
    do_op(4'd9, 32'h8000_0000, 32'h24, 4'h4);
    chk("sra_shamt4", bus.r, 32'hF800_0000);
    do_op(4'd6, 32'd1, 32'hFFFF_FFFF, 4'h5);
    chk("sltu", bus.r, 32'd1);
    do_op(4'd15, 32'd9, 32'd9, 4'h6);
    chk("illegal_op15", {bus.r, bus.illegal, bus.zero}, {32'd0, 2'b11});

    // Back-pressure: result must hold still while the consumer stalls.
    set_rdy(2);
    to_drive();
    send(4'd0, 32'd5, 32'd7, 4'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.r, bus.out_tag}, {2'b10, 32'd12, 4'h3});
    end
    set_rdy(0);
    to_drive();
    send(4'd0, 32'd100, 32'd1, 4'h5);
    @(negedge clk);
    chk("drain_accept", {bus.out_valid, bus.r, bus.out_tag}, {1'b1, 32'd101, 4'h5});

    // MUL latency, counted in edges including the accepting one.
    to_drive();
    send(4'd10, 32'h0001_0001, 32'h0001_0001, 4'h7);
`ifdef ALU_PIPE_MUL_EN
    n = 0;
    stray = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid && bus.in_ready) stray++;
    end while (!bus.out_valid && n < 100);
    chk("mul_in_ready_low", stray, 0);
    chk("mul_latency", n + 1, W + 1);
    chk("mul_result", {bus.r, bus.illegal}, {32'h0002_0001, 1'b0});
`else
    @(negedge clk);
    chk("mul_illegal", {bus.out_valid, bus.illegal, bus.r}, {2'b11, 32'd0});
`endif

    // Reset in the middle of a multiply.
    to_drive();
    send(4'd10, pick(), pick(), 4'h9);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_state", {bus.out_valid, bus.in_ready, bus.r, bus.out_tag},
        {2'b01, 32'd0, 4'h0});
    chk("midreset_flags", {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal}, 5'b10000);
    to_drive();
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    chk("midreset_no_stray_valid", stray, 0);

    // Random traffic under random back-pressure.
    set_rdy(1);
    to_drive();
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 15)), pick(), pick(), 4'($urandom_range(0, 15)));
    end
    set_rdy(0);
    n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
